// File: rtl/lms_weight_update.sv
// LMS coefficient update: w[k] <= sat(w[k] + ((e*x[k]) >>> MU_SHIFT)), one tap per cycle through a shared multiplier.
// Latency: error handshake in cycle 0, w[k] written at edge k+1, upd_done pulses in cycle NTAPS+1, next error in NTAPS+2.
// Backpressure: e_ready only in IDLE; x_ready only in IDLE with no error offered, so an error always wins over a sample.
module lms_weight_update #(
    parameter int NTAPS    = 4,
    parameter int W        = 10,
    parameter int MU_SHIFT = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       x_in,
    input  logic               x_valid,
    output logic               x_ready,
    input  logic [W-1:0]       e_in,
    input  logic               e_valid,
    output logic               e_ready,
    output logic [NTAPS*W-1:0] w_out,
    output logic               busy,
    output logic               upd_done
);

    localparam int            KW     = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic signed [W-1:0]  e_q, e_d;
    logic signed [W-1:0]  x_q [NTAPS];
    logic signed [W-1:0]  w_q [NTAPS];

    logic                 x_fire;
    logic                 e_fire;
    logic signed [W-1:0]  x_sel;
    logic signed [W-1:0]  w_sel;
    logic signed [2*W-1:0] prod;
    logic signed [W:0]    delta;
    logic signed [W:0]    sum;
    logic signed [W-1:0]  w_new;

    assign e_ready = (state_q == IDLE);
    assign x_ready = (state_q == IDLE) && !e_valid;
    assign x_fire  = x_valid && x_ready;
    assign e_fire  = e_valid && e_ready;

    // Next-state logic: capture the error in IDLE, walk the taps in UPDATE, pulse completion in DONE.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        e_d      = e_q;
        busy     = 1'b0;
        upd_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (e_fire) begin
                    e_d     = e_in;
                    k_d     = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                busy     = 1'b1;
                upd_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared datapath: full-width signed product, floor shift, widen by one bit, clamp instead of wrapping.
    always_comb begin
        x_sel = x_q[k_q];
        w_sel = w_q[k_q];
        prod  = x_sel * e_q;
        delta = (W+1)'(prod >>> MU_SHIFT);
        sum   = (W+1)'(w_sel) + delta;
        if (sum[W] != sum[W-1]) begin
            w_new = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            w_new = sum[W-1:0];
        end
    end

    // Control registers; reset aborts any pass in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            e_q     <= e_d;
        end
    end

    // Sample delay line; only moves in IDLE, so a pass sees a frozen snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                x_q[i] <= '0;
            end
        end else if (x_fire) begin
            x_q[0] <= x_in;
            for (int i = 1; i < NTAPS; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    // Weight bank; one tap rewritten per UPDATE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                w_q[i] <= '0;
            end
        end else if (state_q == UPDATE) begin
            w_q[k_q] <= w_new;
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_wout
        assign w_out[g*W +: W] = w_q[g];
    end

endmodule
